// File: rtl/spi_register_writer_if.sv
// Pin bundle between an SPI host, the synth register-write port and the
// sample readback path of spi_register_writer.
interface spi_register_writer_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8
);
  logic                  i_SPI_SCK;
  logic                  i_SPI_CS_n;
  logic                  i_SPI_MOSI;
  logic                  o_SPI_MISO;
  logic                  o_RegisterWriteEnable;
  logic [ADDR_WIDTH-1:0] o_RegisterNumber;
  logic [DATA_WIDTH-1:0] o_RegisterValue;
  logic                  o_FrameError;
  logic [15:0]           i_Sample;
  logic                  i_SampleReady;

  // The SPI-slave / register-writer side.
  modport slave (
    input  i_SPI_SCK, i_SPI_CS_n, i_SPI_MOSI, i_Sample, i_SampleReady,
    output o_SPI_MISO, o_RegisterWriteEnable, o_RegisterNumber,
           o_RegisterValue, o_FrameError
  );

  // The host / environment side.
  modport master (
    output i_SPI_SCK, i_SPI_CS_n, i_SPI_MOSI, i_Sample, i_SampleReady,
    input  o_SPI_MISO, o_RegisterWriteEnable, o_RegisterNumber,
           o_RegisterValue, o_FrameError
  );
endinterface

// File: rtl/spi_register_writer.sv
// SPI mode-0 slave, oversampled on the synth clock, turning 24-bit frames into
// register writes. Define SPI_SAMPLE_READBACK_EN to return synth samples on MISO.
module spi_register_writer #(
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 8
) (
  input logic                  i_Clock,
  input logic                  i_Reset_n,
  spi_register_writer_if.slave bus
);
  localparam int FRAME_BITS = ADDR_WIDTH + DATA_WIDTH;
  localparam int CNT_W      = $clog2(FRAME_BITS);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sck_prev_q, cs_prev_q;
  logic                   sck_s, cs_s, mosi_s;
  logic                   sck_rise, cs_fall, cs_rise;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [FRAME_BITS-1:0]  shift_q, shift_d;
  logic [FRAME_BITS-1:0]  frame_next;
  logic                   frame_done;
  logic                   we_q, we_d;
  logic                   err_q, err_d;
  logic [ADDR_WIDTH-1:0]  number_q, number_d;
  logic [DATA_WIDTH-1:0]  value_q, value_d;

  // Synchronisers shift toward the MSB; the top stage is the usable sample.
  always_comb begin
    sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0],  bus.i_SPI_SCK};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0],   bus.i_SPI_CS_n};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], bus.i_SPI_MOSI};
  end

  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign cs_s     = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev_q;
  assign cs_fall  = ~cs_s & cs_prev_q;
  assign cs_rise  = cs_s & ~cs_prev_q;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    number_d   = number_q;
    value_d    = value_q;
    we_d       = 1'b0;
    err_d      = 1'b0;
    frame_done = 1'b0;
    frame_next = {shift_q[FRAME_BITS-2:0], mosi_s};
    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d   = SHIFT;
          bit_cnt_d = '0;
          shift_d   = '0;
        end
      end
      SHIFT: begin
        if (sck_rise) begin
          if (bit_cnt_q == LAST_BIT) begin
            frame_done = 1'b1;
            we_d       = 1'b1;
            number_d   = frame_next[FRAME_BITS-1:DATA_WIDTH];
            value_d    = frame_next[DATA_WIDTH-1:0];
            shift_d    = '0;
            bit_cnt_d  = '0;
          end else begin
            shift_d   = frame_next;
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
        // A frame finishing on the same cycle as CS rising leaves the count
        // at zero, so it is written and not flagged.
        if (cs_rise) begin
          state_d   = IDLE;
          err_d     = (bit_cnt_d != '0);
          bit_cnt_d = '0;
          shift_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      sck_sync_q  <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sck_prev_q  <= 1'b0;
      cs_prev_q   <= 1'b1;
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      we_q        <= 1'b0;
      err_q       <= 1'b0;
      number_q    <= '0;
      value_q     <= '0;
    end else begin
      sck_sync_q  <= sck_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sck_prev_q  <= sck_s;
      cs_prev_q   <= cs_s;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      we_q        <= we_d;
      err_q       <= err_d;
      number_q    <= number_d;
      value_q     <= value_d;
    end
  end

  assign bus.o_RegisterWriteEnable = we_q;
  assign bus.o_RegisterNumber      = number_q;
  assign bus.o_RegisterValue       = value_q;
  assign bus.o_FrameError          = err_q;

`ifdef SPI_SAMPLE_READBACK_EN
  logic        sck_fall;
  logic [15:0] hold_q, hold_d;
  logic [15:0] miso_sr_q, miso_sr_d;
  logic        miso_q, miso_d;

  assign sck_fall = ~sck_s & sck_prev_q;

  // The holding register is the only thing a sample strobe touches; the shift
  // register reloads from it only at frame boundaries.
  always_comb begin
    hold_d    = bus.i_SampleReady ? bus.i_Sample : hold_q;
    miso_sr_d = miso_sr_q;
    miso_d    = miso_q;
    if (state_q == IDLE) begin
      if (cs_fall) begin
        miso_sr_d = hold_q;
        miso_d    = hold_q[15];
      end
    end else if (cs_rise) begin
      miso_d = 1'b0;
    end else if (frame_done) begin
      miso_sr_d = hold_q;
      miso_d    = hold_q[15];
    end else if (sck_fall) begin
      if (bit_cnt_q != '0 && bit_cnt_q < CNT_W'(16)) begin
        miso_d    = miso_sr_q[14];
        miso_sr_d = {miso_sr_q[14:0], 1'b0};
      end else if (bit_cnt_q >= CNT_W'(16)) begin
        miso_d = 1'b0;
      end
    end
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      hold_q    <= '0;
      miso_sr_q <= '0;
      miso_q    <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      miso_sr_q <= miso_sr_d;
      miso_q    <= miso_d;
    end
  end

  assign bus.o_SPI_MISO = miso_q;
`else
  logic unused_readback;
  assign unused_readback = ^{bus.i_Sample, bus.i_SampleReady, frame_done};
  assign bus.o_SPI_MISO  = 1'b0;
`endif
endmodule

// File: tb/tb_spi_register_writer.sv
// Randomised bench for spi_register_writer: a bit-list model predicts writes,
// frame errors and MISO data; a monitor logs every strobe.
module tb_spi_register_writer;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   err_cycles;
  int   exp_err;
  logic [23:0] exp_q[$];
  logic [23:0] obs_q[$];
  logic [23:0] prev_out;

  spi_register_writer_if bus ();

  spi_register_writer dut (
    .i_Clock  (clk),
    .i_Reset_n(rst_n),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  // Monitor: logs writes, counts error cycles, checks hold and idle MISO.
  always @(posedge clk) begin
    #1;
    if (rst_n === 1'b1) begin
      if (bus.o_RegisterWriteEnable === 1'b1) begin
        obs_q.push_back({bus.o_RegisterNumber, bus.o_RegisterValue});
        $display("write number=%04h value=%02h t=%0t", bus.o_RegisterNumber, bus.o_RegisterValue, $time);
      end
      if (bus.o_FrameError === 1'b1) err_cycles++;
      total++;
      if (bus.o_RegisterWriteEnable !== 1'b1 && {bus.o_RegisterNumber, bus.o_RegisterValue} !== prev_out) begin
        bad++;
        $display("FAIL hold: outputs changed without strobe, got %06h required %06h", {bus.o_RegisterNumber, bus.o_RegisterValue}, prev_out);
      end
`ifndef SPI_SAMPLE_READBACK_EN
      total++;
      if (bus.o_SPI_MISO !== 1'b0) begin
        bad++;
        $display("FAIL miso_idle: got %b required 0", bus.o_SPI_MISO);
      end
`endif
    end
    prev_out = {bus.o_RegisterNumber, bus.o_RegisterValue};
  end

  task automatic clear_log();
    exp_q.delete();
    obs_q.delete();
    err_cycles = 0;
    exp_err    = 0;
  endtask

  task automatic spi_bit(input bit b, input int half, output logic m);
    bus.i_SPI_MOSI = b;
    repeat (half) @(negedge clk);
    m = bus.o_SPI_MISO;
    bus.i_SPI_SCK = 1'b1;
    repeat (half) @(negedge clk);
    bus.i_SPI_SCK = 1'b0;
  endtask

  // Drives one CS assertion and predicts its writes: every whole group of
  // 24 bits is one write, a leftover tail is one frame error.
  task automatic run_cs(input bit bits[$], input int half);
    logic m;
    logic [23:0] w;
    int nfull;
    bus.i_SPI_CS_n = 1'b0;
    repeat (4) @(negedge clk);
    foreach (bits[i]) spi_bit(bits[i], half, m);
    repeat (half) @(negedge clk);
    bus.i_SPI_CS_n = 1'b1;
    repeat (10) @(negedge clk);
    nfull = bits.size() / 24;
    for (int k = 0; k < nfull; k++) begin
      w = '0;
      for (int j = 0; j < 24; j++) w[23-j] = bits[24*k+j];
      exp_q.push_back(w);
    end
    if (bits.size() % 24 != 0) exp_err++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.i_SPI_SCK = 1'b0;
    bus.i_SPI_CS_n = 1'b1;
    bus.i_SPI_MOSI = 1'b0;
    bus.i_Sample = 16'h0;
    bus.i_SampleReady = 1'b0;
    clear_log();
    repeat (3) @(negedge clk);
    total++;
    if ({bus.o_RegisterWriteEnable, bus.o_FrameError, bus.o_SPI_MISO} !== 3'b000) begin
      bad++;
      $display("FAIL reset_strobes: got %b required 000", {bus.o_RegisterWriteEnable, bus.o_FrameError, bus.o_SPI_MISO});
    end
    total++;
    if ({bus.o_RegisterNumber, bus.o_RegisterValue} !== 24'h0) begin
      bad++;
      $display("FAIL reset_data: got %06h required 000000", {bus.o_RegisterNumber, bus.o_RegisterValue});
    end
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    total++;
    if (obs_q.size() != 0 || err_cycles != 0) begin
      bad++;
      $display("FAIL reset_release: got writes=%0d errs=%0d required 0/0", obs_q.size(), err_cycles);
    end
  endtask

  task automatic test_single();
    bit bits[$];
    logic [23:0] f;
    clear_log();
    f = 24'hC0057F;
    for (int j = 23; j >= 0; j--) bits.push_back(f[j]);
    run_cs(bits, 5);
    total++;
    if (obs_q.size() != 1) begin
      bad++;
      $display("FAIL single_count: got %0d writes required 1", obs_q.size());
    end else begin
      total++;
      if (obs_q[0] !== 24'hC0057F) begin
        bad++;
        $display("FAIL single_data: got %06h required c0057f", obs_q[0]);
      end
    end
    total++;
    if (err_cycles != 0) begin
      bad++;
      $display("FAIL single_err: got %0d error cycles required 0", err_cycles);
    end
  endtask

  task automatic test_back_to_back();
    bit bits[$];
    logic [47:0] f;
    clear_log();
    f = 48'h800001_800103;
    for (int j = 47; j >= 0; j--) bits.push_back(f[j]);
    run_cs(bits, 4);
    total++;
    if (obs_q.size() != 2) begin
      bad++;
      $display("FAIL b2b_count: got %0d writes required 2", obs_q.size());
    end else begin
      total++;
      if (obs_q[0] !== 24'h800001 || obs_q[1] !== 24'h800103) begin
        bad++;
        $display("FAIL b2b_order: got %06h,%06h required 800001,800103", obs_q[0], obs_q[1]);
      end
    end
    total++;
    if ({bus.o_RegisterNumber, bus.o_RegisterValue} !== 24'h800103) begin
      bad++;
      $display("FAIL b2b_hold: got %06h required 800103", {bus.o_RegisterNumber, bus.o_RegisterValue});
    end
  endtask

  task automatic test_partial();
    bit bits[$];
    logic [23:0] f;
    clear_log();
    for (int j = 0; j < 10; j++) bits.push_back(1'($urandom));
    run_cs(bits, 5);
    total++;
    if (obs_q.size() != 0 || err_cycles != 1) begin
      bad++;
      $display("FAIL partial: got writes=%0d err_cycles=%0d required 0/1", obs_q.size(), err_cycles);
    end
    clear_log();
    bits.delete();
    f = 24'hC100AA;
    for (int j = 23; j >= 0; j--) bits.push_back(f[j]);
    run_cs(bits, 5);
    total++;
    if (obs_q.size() != 1 || obs_q[0] !== 24'hC100AA || err_cycles != 0) begin
      bad++;
      $display("FAIL after_partial: got writes=%0d first=%06h errs=%0d required 1/c100aa/0",
               obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 24'h0, err_cycles);
    end
  endtask

  task automatic test_reset_mid_frame();
    bit bits[$];
    logic [23:0] f;
    logic m;
    clear_log();
    f = 24'hC20012;
    bus.i_SPI_CS_n = 1'b0;
    repeat (4) @(negedge clk);
    for (int j = 23; j >= 4; j--) spi_bit(f[j], 5, m);
    rst_n = 1'b0;
    #1;
    total++;
    if ({bus.o_RegisterWriteEnable, bus.o_FrameError, bus.o_RegisterNumber, bus.o_RegisterValue} !== 26'h0) begin
      bad++;
      $display("FAIL reset_mid: got we=%b err=%b data=%06h required all 0",
               bus.o_RegisterWriteEnable, bus.o_FrameError, {bus.o_RegisterNumber, bus.o_RegisterValue});
    end
    bus.i_SPI_CS_n = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    f = 24'($urandom);
    for (int j = 23; j >= 0; j--) bits.push_back(f[j]);
    run_cs(bits, 5);
    total++;
    if (obs_q.size() != 1 || obs_q[0] !== f || err_cycles != 0) begin
      bad++;
      $display("FAIL reset_recover: got writes=%0d first=%06h errs=%0d required 1/%06h/0",
               obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 24'h0, err_cycles, f);
    end
  endtask

  task automatic test_idle_sck();
    logic m;
    clear_log();
    for (int j = 0; j < 30; j++) spi_bit(1'($urandom), 4, m);
    repeat (10) @(negedge clk);
    total++;
    if (obs_q.size() != 0 || err_cycles != 0) begin
      bad++;
      $display("FAIL idle_sck: got writes=%0d errs=%0d required 0/0", obs_q.size(), err_cycles);
    end
  endtask

  task automatic test_random();
    bit bits[$];
    int half;
    int nbits;
    for (int it = 0; it < 15; it++) begin
      clear_log();
      bits.delete();
      half  = $urandom_range(4, 7);
      nbits = 24 * $urandom_range(1, 3);
      if ($urandom_range(0, 2) == 0) nbits += $urandom_range(1, 23);
      for (int j = 0; j < nbits; j++) bits.push_back(1'($urandom));
      run_cs(bits, half);
      total++;
      if (obs_q.size() != exp_q.size()) begin
        bad++;
        $display("FAIL rand_count[%0d]: got %0d writes required %0d", it, obs_q.size(), exp_q.size());
      end else begin
        foreach (exp_q[k]) begin
          total++;
          if (obs_q[k] !== exp_q[k]) begin
            bad++;
            $display("FAIL rand_data[%0d.%0d]: got %06h required %06h", it, k, obs_q[k], exp_q[k]);
          end
        end
      end
      total++;
      if (err_cycles != exp_err) begin
        bad++;
        $display("FAIL rand_err[%0d]: got %0d error cycles required %0d", it, err_cycles, exp_err);
      end
    end
  endtask

  task automatic test_readback();
    logic m;
    logic [47:0] rx;
    logic [47:0] exp_rx;
    bit b;
    clear_log();
    rx = '0;
    bus.i_Sample = 16'hA5C3;
    bus.i_SampleReady = 1'b1;
    @(negedge clk);
    bus.i_SampleReady = 1'b0;
    bus.i_SPI_CS_n = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 48; i++) begin
      if (i == 5) begin
        // New sample mid-frame must only surface in the following frame.
        bus.i_Sample = 16'h1234;
        bus.i_SampleReady = 1'b1;
        @(negedge clk);
        bus.i_SampleReady = 1'b0;
      end
      b = 1'($urandom);
      spi_bit(b, 5, m);
      rx[47-i] = m;
    end
    repeat (5) @(negedge clk);
    bus.i_SPI_CS_n = 1'b1;
    repeat (10) @(negedge clk);
`ifdef SPI_SAMPLE_READBACK_EN
    exp_rx = 48'hA5C3_00_1234_00;
`else
    exp_rx = 48'h0;
`endif
    total++;
    if (rx !== exp_rx) begin
      bad++;
      $display("FAIL readback: got %012h required %012h", rx, exp_rx);
    end
    total++;
    if (obs_q.size() != 2 || err_cycles != 0) begin
      bad++;
      $display("FAIL readback_writes: got writes=%0d errs=%0d required 2/0", obs_q.size(), err_cycles);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_partial();
    test_reset_mid_frame();
    test_idle_sck();
    test_random();
    test_readback();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/spi_register_writer.md
Name: spi_register_writer

Overview:
- SPI mode-0 slave that turns serial host frames into register writes on synth's parallel register-write port (register write enable, 16-bit register number, 8-bit value).
- It is the writer side of that interface and replaces direct host drive of the synth register port.
- It runs entirely on the synth clock. SCK, CS and MOSI are oversampled through synchronisers, so there is no second clock domain.

Parameters:
- SYNC_STAGES, 2, number of flip-flop synchroniser stages on SCK, CS_n and MOSI; minimum 2.
- ADDR_WIDTH, 16, register-number field width.
- DATA_WIDTH, 8, register-value field width. Frame length is ADDR_WIDTH+DATA_WIDTH (24 bits).

Ports:
- i_Clock  in  1  system clock; must run at least 8x the SCK frequency.
- i_Reset_n  in  1  asynchronous active-low reset.
- i_SPI_SCK  in  1  SPI clock, mode 0 (CPOL=0, CPHA=0).
- i_SPI_CS_n  in  1  active-low chip select.
- i_SPI_MOSI  in  1  serial data in, MSB first.
- o_SPI_MISO  out  1  serial data out (see Optional Feature).
- o_RegisterWriteEnable  out  1  one-cycle write strobe.
- o_RegisterNumber  out  ADDR_WIDTH  register number for the write.
- o_RegisterValue  out  DATA_WIDTH  register value for the write.
- o_FrameError  out  1  one-cycle pulse when a partial frame is discarded.
- i_Sample  in  16  synth output sample (used only with the optional feature).
- i_SampleReady  in  1  sample-valid strobe (used only with the optional feature).

Behaviour:
- Reset (async assert, sync deassert): all outputs 0, FSM in IDLE, bit counter 0, shift registers 0, synchroniser chains preset to CS_n=1, SCK=0, MOSI=0.
- Synchronisation: SCK, CS_n and MOSI each pass through SYNC_STAGES flops. Edges are detected by comparing the last synchronised stage with one further registered copy.
- FSM has two states, IDLE and SHIFT.
- IDLE -> SHIFT on a synchronised CS_n falling edge. Bit counter clears.
- SHIFT -> IDLE on a synchronised CS_n rising edge.
- In SHIFT, on each synchronised SCK rising edge:
  - shift MOSI into a 24-bit shift register (LSB in);
  - increment the bit counter.
- When the counter reaches 24 (bits 23..8 = number, 7..0 = value):
  - next clock: o_RegisterNumber/o_RegisterValue update and o_RegisterWriteEnable is high for exactly one cycle;
  - counter returns to 0 and the FSM stays in SHIFT, so back-to-back frames within one CS assertion each produce a write.
- o_RegisterNumber and o_RegisterValue hold their values between writes. They change only in the cycle the strobe asserts.
- No address filtering: every complete frame is written, and synth ignores invalid numbers.
- CS_n rise with counter != 0: discard the partial frame, no write, o_FrameError pulses for one cycle. With counter == 0, no pulse.
- CS_n rise coinciding with the 24th SCK edge detection: the write completes and no error pulse.
- SCK edges while in IDLE are ignored.
- Reset asserted mid-frame: frame lost, outputs immediately 0, no strobe issued.
- MISO in mode 0: the output changes on a synchronised SCK falling edge. The first bit is driven in the cycle after the CS_n falling edge detection.

Optional Feature:
- Macro: SPI_SAMPLE_READBACK_EN.
- Defined:
  - a 16-bit holding register captures i_Sample on every i_SampleReady;
  - on CS_n falling edge, and again at the start of each subsequent frame (counter wraps to 0), the holding value loads into a 16-bit MISO shift register;
  - MISO presents bit 15 first and advances one bit per SCK falling edge during frame bits 0..15, then drives 0 for bits 16..23;
  - an i_SampleReady arriving mid-frame updates the holding register only, never the shift register in flight.
- Undefined: o_SPI_MISO is constant 0; i_Sample and i_SampleReady are unused and the holding logic is absent.

Test Plan:
- CS low, shift 24 bits 0xC0_05_7F, CS high -> exactly one strobe, o_RegisterNumber=0xC005, o_RegisterValue=0x7F, o_FrameError stays 0.
- One CS assertion carrying frames 0x8000_01 then 0x8001_03 -> two strobes in order: 0x8000/0x01 then 0x8001/0x03. Outputs hold 0x8001/0x03 afterwards.
- CS low, 10 bits, CS high -> no strobe, one-cycle o_FrameError. A following full frame 0xC100_AA writes correctly.
- Drop i_Reset_n after 20 bits of 0xC20012 -> all outputs 0 immediately. After release, a full frame writes normally with no stale bits.
- SCK toggling with CS high -> no strobe and no error. SCK at clock/8 (minimum ratio) -> all writes correct.
- With SPI_SAMPLE_READBACK_EN: pulse i_SampleReady with i_Sample=0xA5C3, then run a frame -> MISO returns 1010010111000011 then eight 0s. Without the macro -> MISO is always 0.
